// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issue stage and the iterative RV32M multiply/divide unit.
// The master drives the operation request; the slave returns the write-back tuple.
interface muldiv_unit_if #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      start;
    logic [2:0]                funct3;
    logic [XLEN-1:0]           op_a;
    logic [XLEN-1:0]           op_b;
    logic [REG_ADDR_WIDTH-1:0] rd_in;
    logic                      kill;
    logic                      busy;
    logic                      done;
    logic [XLEN-1:0]           result;
    logic [REG_ADDR_WIDTH-1:0] rd_out;
    logic                      we_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, kill,
        input  busy, done, result, rd_out, we_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, kill,
        output busy, done, result, rd_out, we_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on operand
// magnitudes, one bit per clock, with sign correction after the last step.
module muldiv_unit #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ZERO      = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [CNT_W-1:0]          cnt_r;
    logic [2:0]                funct3_r;
    logic [REG_ADDR_WIDTH-1:0] rd_r, rd_out_r;
    logic [XLEN-1:0]           acc_hi_r, acc_lo_r, opd_r, res_r, result_r;
    logic                      neg_q_r, neg_r_r, busy_r, done_r, we_r;

    logic                      accept_s, special_s, b_zero_s, ovf_s;
    logic                      a_signed_s, b_signed_s, a_neg_s, b_neg_s;
    logic [XLEN-1:0]           a_mag_s, b_mag_s, spec_res_s;
    logic [XLEN-1:0]           hi_nx_s, lo_nx_s, final_s;
    logic [XLEN:0]             mul_sum_s, rem_sh_s, diff_s;
    logic [2*XLEN-1:0]         prod_s, prod_fix_s;

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    // Operand signedness per funct3 and magnitudes for the unsigned core
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (bus.funct3)
            F_MULH, F_DIV, F_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            F_MULHSU: a_signed_s = 1'b1;
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        a_neg_s = a_signed_s & bus.op_a[XLEN-1];
        b_neg_s = b_signed_s & bus.op_b[XLEN-1];
        a_mag_s = neg_if(a_neg_s, bus.op_a);
        b_mag_s = neg_if(b_neg_s, bus.op_b);
    end

    // Divide-by-zero and signed-overflow fast path, resolved at accept
    always_comb begin
        b_zero_s  = (bus.op_b == ZERO);
        ovf_s     = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                    (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
        special_s = bus.funct3[2] & (b_zero_s | ovf_s);
        if (b_zero_s) begin
            spec_res_s = bus.funct3[1] ? bus.op_a : ALL_ONES;
        end else if (ovf_s) begin
            spec_res_s = bus.funct3[1] ? ZERO : MIN_NEG;
        end else begin
            spec_res_s = ZERO;
        end
    end

    // One iteration: acc_hi:acc_lo is the product (multiply) or remainder:quotient (divide)
    always_comb begin
        mul_sum_s = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opd_r} : {(XLEN+1){1'b0}});
        rem_sh_s  = {acc_hi_r, acc_lo_r[XLEN-1]};
        diff_s    = rem_sh_s - {1'b0, opd_r};
        if (funct3_r[2]) begin
            if (!diff_s[XLEN]) begin
                hi_nx_s = diff_s[XLEN-1:0];
                lo_nx_s = {acc_lo_r[XLEN-2:0], 1'b1};
            end else begin
                hi_nx_s = rem_sh_s[XLEN-1:0];
                lo_nx_s = {acc_lo_r[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nx_s = mul_sum_s[XLEN:1];
            lo_nx_s = {mul_sum_s[0], acc_lo_r[XLEN-1:1]};
        end
    end

    // Sign correction and result selection applied to the final iteration's output
    always_comb begin
        prod_s     = {hi_nx_s, lo_nx_s};
        prod_fix_s = neg_q_r ? -prod_s : prod_s;
        case (funct3_r)
            F_MUL:                      final_s = prod_fix_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU:  final_s = prod_fix_s[2*XLEN-1:XLEN];
            F_DIV, F_DIVU:              final_s = neg_if(neg_q_r, lo_nx_s);
            F_REM, F_REMU:              final_s = neg_if(neg_r_r, hi_nx_s);
            default:                    final_s = ZERO;
        endcase
    end

    // Next-state logic; kill wins over start, and start is ignored while iterating
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.kill) begin
                    state_s = IDLE;
                end else if (bus.start) begin
                    accept_s = 1'b1;
                    state_s  = special_s ? DONE : CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_s = IDLE;
                end else if (cnt_r == LAST_ITER) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latch at accept and datapath iteration while in CALC
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            funct3_r <= 3'd0;
            rd_r     <= {REG_ADDR_WIDTH{1'b0}};
            acc_hi_r <= ZERO;
            acc_lo_r <= ZERO;
            opd_r    <= ZERO;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            res_r    <= ZERO;
        end else if (accept_s) begin
            cnt_r    <= CNT_ZERO;
            funct3_r <= bus.funct3;
            rd_r     <= bus.rd_in;
            acc_hi_r <= ZERO;
            acc_lo_r <= a_mag_s;
            opd_r    <= b_mag_s;
            neg_q_r  <= a_neg_s ^ b_neg_s;
            neg_r_r  <= a_neg_s;
            res_r    <= spec_res_s;
        end else if (state_r == CALC) begin
            cnt_r    <= cnt_r + CNT_ONE;
            acc_hi_r <= hi_nx_s;
            acc_lo_r <= lo_nx_s;
            if (cnt_r == LAST_ITER) begin
                res_r <= final_s;
            end
        end
    end

    // Registered write-back outputs; the done pulse follows the cycle spent in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            we_r     <= 1'b0;
            result_r <= ZERO;
            rd_out_r <= {REG_ADDR_WIDTH{1'b0}};
        end else begin
            busy_r <= (state_s == CALC);
            done_r <= (state_r == DONE);
            we_r   <= (state_r == DONE) && (rd_r != {REG_ADDR_WIDTH{1'b0}});
            if (state_r == DONE) begin
                result_r <= res_r;
                rd_out_r <= rd_r;
            end
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.we_out = we_r;
    assign bus.result = result_r;
    assign bus.rd_out = rd_out_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized operations against
// an arithmetic reference model, and kill/reset/back-to-back handshake scenarios.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW)) bus ();

    muldiv_unit #(.XLEN(XLEN), .REG_ADDR_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs [14] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd5},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd1},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5'd2},
        '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 5'd3},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 5'd4},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 5'd6},
        '{3'd5, 32'd100,       32'd7,         32'd14,        5'd7},
        '{3'd7, 32'd100,       32'd7,         32'd2,         5'd8},
        '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd9},
        '{3'd6, 32'd5,         32'd0,         32'd5,         5'd10},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd11},
        '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 5'd12},
        '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 5'd13},
        '{3'd7, 32'd9,         32'd0,         32'd9,         5'd31}
    };

    // Reference: RV32M semantics straight from 64-bit integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        int          ia, ib;
        logic [31:0] r;
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
            3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
            3'd2: begin p = longint'($signed(a)) * longint'({32'h0, b}); r = p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            3'd4: r = (b == 32'h0) ? 32'hFFFF_FFFF :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            3'd5: r = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 32'h0) ? a :
                      (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
            default: r = (b == 32'h0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        bit fast;
        fast = f[2] && ((b == 32'h0) ||
               ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return fast ? 1 : XLEN + 1;
    endfunction

    // Drive one request; returns #1 after the accept edge with inputs scrambled
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit now);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.rd_in  = 5'($urandom);
    endtask

    task automatic wait_done(input int limit, output int lat, output bit busy_first,
                             output bit busy_any);
        lat        = 0;
        busy_first = bus.busy;
        busy_any   = bus.busy;
        while (bus.done !== 1'b1 && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy === 1'b1) busy_any = 1'b1;
        end
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0 || bus.we_out !== 1'b0) cnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_cmp++; if (bus.we_out !== 1'b0) begin n_bad++; $display("FAIL reset_we got %b want 0", bus.we_out); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", bus.result); end
        n_cmp++; if (bus.rd_out !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", bus.rd_out); end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        int lat;
        bit bf, ba;
        int exp_lat;
        foreach (vecs[i]) begin
            exp_lat = ref_latency(vecs[i].f, vecs[i].a, vecs[i].b);
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, 1'b0);
            wait_done(200, lat, bf, ba);
            n_cmp++; if (lat != exp_lat) begin n_bad++; $display("FAIL directed[%0d] latency got %0d want %0d", i, lat, exp_lat); end
            n_cmp++; if (bus.result !== vecs[i].exp) begin n_bad++; $display("FAIL directed[%0d] result got %h want %h", i, bus.result, vecs[i].exp); end
            n_cmp++; if (bus.rd_out !== vecs[i].rd) begin n_bad++; $display("FAIL directed[%0d] rd_out got %0d want %0d", i, bus.rd_out, vecs[i].rd); end
            n_cmp++; if (bus.we_out !== 1'b1) begin n_bad++; $display("FAIL directed[%0d] we_out got %b want 1", i, bus.we_out); end
            if (exp_lat == 1) begin
                n_cmp++; if (ba !== 1'b0) begin n_bad++; $display("FAIL directed[%0d] fast_busy got %b want 0", i, ba); end
            end else begin
                n_cmp++; if (bf !== 1'b1) begin n_bad++; $display("FAIL directed[%0d] busy_after_accept got %b want 1", i, bf); end
            end
            @(posedge clk);
            #1;
            n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL directed[%0d] done_width got %b want 0", i, bus.done); end
        end
    endtask

    task automatic test_random();
        int          lat, mode;
        bit          bf, ba;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        for (int i = 0; i < 60; i++) begin
            f    = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            rd   = 5'($urandom_range(0, 31));
            mode = $urandom_range(0, 5);
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (mode == 2) begin a = 32'($urandom_range(0, 300)) - 32'd150; b = 32'($urandom_range(1, 20)); end
            issue(f, a, b, rd, 1'b0);
            wait_done(200, lat, bf, ba);
            n_cmp++; if (lat != ref_latency(f, a, b)) begin n_bad++; $display("FAIL random[%0d] latency f=%0d got %0d want %0d", i, f, lat, ref_latency(f, a, b)); end
            n_cmp++; if (bus.result !== ref_result(f, a, b)) begin n_bad++; $display("FAIL random[%0d] result f=%0d a=%h b=%h got %h want %h", i, f, a, b, bus.result, ref_result(f, a, b)); end
            n_cmp++; if (bus.rd_out !== rd) begin n_bad++; $display("FAIL random[%0d] rd_out got %0d want %0d", i, bus.rd_out, rd); end
            n_cmp++; if (bus.we_out !== (rd != 5'd0)) begin n_bad++; $display("FAIL random[%0d] we_out got %b want %b", i, bus.we_out, rd != 5'd0); end
        end
    endtask

    task automatic test_kill_calc();
        int cnt;
        issue(3'd0, $urandom, $urandom, 5'd3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        bus.kill = 1'b1;
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill_calc busy got %b want 0", bus.busy); end
        count_dones(45, cnt);
        n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL kill_calc done_count got %0d want 0", cnt); end
    endtask

    task automatic test_kill_idle();
        int cnt;
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.kill   = 1'b1;
        bus.funct3 = 3'd5;
        bus.op_a   = 32'd5;
        bus.op_b   = 32'd0;
        bus.rd_in  = 5'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.kill  = 1'b0;
        count_dones(40, cnt);
        n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL kill_idle done_count got %0d want 0", cnt); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL kill_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_start_while_busy();
        int          lat, cnt;
        bit          bf, ba;
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom | 32'h1;
        issue(3'd5, a, b, 5'd17, 1'b0);
        for (int k = 0; k < XLEN - 5; k++) begin
            bus.start  = 1'b1;
            bus.funct3 = 3'($urandom);
            bus.op_a   = $urandom;
            bus.op_b   = $urandom;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_done(200, lat, bf, ba);
        n_cmp++; if (lat + XLEN - 5 != XLEN + 1) begin n_bad++; $display("FAIL busy_start latency got %0d want %0d", lat + XLEN - 5, XLEN + 1); end
        n_cmp++; if (bus.result !== a / b) begin n_bad++; $display("FAIL busy_start result got %h want %h", bus.result, a / b); end
        n_cmp++; if (bus.rd_out !== 5'd17) begin n_bad++; $display("FAIL busy_start rd_out got %0d want 17", bus.rd_out); end
        count_dones(40, cnt);
        n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL busy_start extra_done got %0d want 0", cnt); end
    endtask

    task automatic test_rst_mid_calc();
        int lat, cnt;
        bit bf, ba;
        issue(3'd0, 32'd3, 32'd5, 5'd7, 1'b0);
        wait_done(200, lat, bf, ba);
        n_cmp++; if (bus.result !== 32'd15) begin n_bad++; $display("FAIL rst_mid pre_result got %h want f", bus.result); end
        issue(3'd4, $urandom, 32'd3, 5'd8, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_mid done got %b want 0", bus.done); end
        n_cmp++; if (bus.we_out !== 1'b0) begin n_bad++; $display("FAIL rst_mid we got %b want 0", bus.we_out); end
        n_cmp++; if (bus.result !== 32'h0) begin n_bad++; $display("FAIL rst_mid result got %h want 0", bus.result); end
        n_cmp++; if (bus.rd_out !== 5'd0) begin n_bad++; $display("FAIL rst_mid rd_out got %0d want 0", bus.rd_out); end
        rst = 1'b0;
        count_dones(40, cnt);
        n_cmp++; if (cnt != 0) begin n_bad++; $display("FAIL rst_mid late_done got %0d want 0", cnt); end
    endtask

    task automatic test_rd_zero();
        int lat;
        bit bf, ba;
        issue(3'd0, 32'd3, 32'd4, 5'd0, 1'b0);
        wait_done(200, lat, bf, ba);
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL rd_zero done got %b want 1", bus.done); end
        n_cmp++; if (bus.result !== 32'd12) begin n_bad++; $display("FAIL rd_zero result got %h want c", bus.result); end
        n_cmp++; if (bus.we_out !== 1'b0) begin n_bad++; $display("FAIL rd_zero we_out got %b want 0", bus.we_out); end
    endtask

    task automatic test_back_to_back();
        int          lat;
        bit          bf, ba;
        logic [31:0] a1, b1, a2, b2, r1;
        a1 = $urandom;
        b1 = $urandom;
        a2 = $urandom;
        b2 = $urandom | 32'h1;
        r1 = ref_result(3'd0, a1, b1);
        issue(3'd0, a1, b1, 5'd21, 1'b0);
        wait_done(200, lat, bf, ba);
        issue(3'd7, a2, b2, 5'd22, 1'b1);
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL b2b done_width got %b want 0", bus.done); end
        n_cmp++; if (bus.result !== r1) begin n_bad++; $display("FAIL b2b held_result got %h want %h", bus.result, r1); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b second_busy got %b want 1", bus.busy); end
        wait_done(200, lat, bf, ba);
        n_cmp++; if (lat != XLEN + 1) begin n_bad++; $display("FAIL b2b latency got %0d want %0d", lat, XLEN + 1); end
        n_cmp++; if (bus.result !== a2 % b2) begin n_bad++; $display("FAIL b2b result got %h want %h", bus.result, a2 % b2); end
        n_cmp++; if (bus.rd_out !== 5'd22) begin n_bad++; $display("FAIL b2b rd_out got %0d want 22", bus.rd_out); end
    endtask

    task automatic test_kill_done();
        int lat;
        bit bf, ba;
        issue(3'd0, 32'd6, 32'd7, 5'd9, 1'b0);
        wait_done(200, lat, bf, ba);
        bus.kill = 1'b1;
        #1;
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL kill_done pulse got %b want 1", bus.done); end
        @(posedge clk);
        #1;
        bus.kill = 1'b0;
        n_cmp++; if (bus.result !== 32'd42) begin n_bad++; $display("FAIL kill_done held_result got %h want 2a", bus.result); end
        n_cmp++; if (bus.rd_out !== 5'd9) begin n_bad++; $display("FAIL kill_done held_rd got %0d want 9", bus.rd_out); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.kill   = 1'b0;
        bus.funct3 = 3'd0;
        bus.op_a   = 32'h0;
        bus.op_b   = 32'h0;
        bus.rd_in  = 5'd0;
        test_reset();
        test_directed();
        test_random();
        test_kill_calc();
        test_kill_idle();
        test_start_while_busy();
        test_rst_mid_calc();
        test_rd_zero();
        test_back_to_back();
        test_kill_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
